// File: rtl/cnn_mul_pkg.sv
// rtl/cnn_mul_pkg.sv - shared widths, operand types and round-robin pick helper
package cnn_mul_pkg;

  localparam int A_WIDTH  = 14;
  localparam int B_WIDTH  = 6;
  localparam int P_WIDTH  = A_WIDTH + B_WIDTH;
  localparam int MAX_NREQ = 16;

  typedef logic signed [A_WIDTH-1:0] a_t;
  typedef logic signed [B_WIDTH-1:0] b_t;
  typedef logic signed [P_WIDTH-1:0] p_t;

  // Returns {found, idx}: first valid requester at or after ptr, wrapping mod nreq.
  // Walking downward lets the lowest distance from ptr win by being assigned last.
  function automatic logic [4:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                         input logic [3:0] ptr,
                                         input int nreq);
    logic [4:0] r;
    int j;
    r = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        j = int'(ptr) + k;
        if (j >= nreq) j = j - nreq;
        if (valid[j[3:0]]) r = {1'b1, j[3:0]};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_mul_share_dsp.sv
// rtl/cnn_mul_share_dsp.sv - combinational signed multiply, registered on both sides by the parent
module cnn_mul_share_dsp #(
  parameter int AW = cnn_mul_pkg::A_WIDTH,
  parameter int BW = cnn_mul_pkg::B_WIDTH
) (
  input  logic signed [AW-1:0]    a,
  input  logic signed [BW-1:0]    b,
  output logic signed [AW+BW-1:0] p
);

  logic signed [AW+BW-1:0] ae;
  logic signed [AW+BW-1:0] be;

  // Extend both operands to product width so the truncated result stays exact.
  assign ae = {{BW{a[AW-1]}}, a};
  assign be = {{AW{b[BW-1]}}, b};
  assign p  = ae * be;

endmodule

// File: rtl/cnn_mul_share_arbiter.sv
// rtl/cnn_mul_share_arbiter.sv - round-robin share of one signed multiplier across NREQ lanes
module cnn_mul_share_arbiter
  import cnn_mul_pkg::rr_pick;
#(
  parameter int NREQ    = 4,
  parameter int A_WIDTH = cnn_mul_pkg::A_WIDTH,
  parameter int B_WIDTH = cnn_mul_pkg::B_WIDTH,
  parameter int TAG_W   = $clog2(NREQ)
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         stall,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*A_WIDTH-1:0]      req_a,
  input  logic [NREQ*B_WIDTH-1:0]      req_b,
  output logic [NREQ-1:0]              req_ready,
  output logic                         res_valid,
  output logic [TAG_W-1:0]             res_tag,
  output logic [A_WIDTH+B_WIDTH-1:0]   res_p,
  output logic                         busy
);

  localparam int P_W = A_WIDTH + B_WIDTH;

  logic [3:0]                 rr_ptr;
  logic [4:0]                 pick;
  logic [3:0]                 win_idx;
  logic                       grant;
  logic signed [A_WIDTH-1:0]  a_sel;
  logic signed [B_WIDTH-1:0]  b_sel;

  logic                       s1_v;
  logic signed [A_WIDTH-1:0]  a1;
  logic signed [B_WIDTH-1:0]  b1;
  logic [TAG_W-1:0]           tag1;
  logic                       s2_v;
  logic signed [P_W-1:0]      p2;
  logic [TAG_W-1:0]           tag2;
  logic signed [P_W-1:0]      prod;

  assign pick    = rr_pick(16'(req_valid), rr_ptr, NREQ);
  assign win_idx = pick[3:0];
  assign grant   = pick[4] & ~stall;

  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 4'(i)) begin
        req_ready[i] = grant;
        a_sel        = req_a[i*A_WIDTH +: A_WIDTH];
        b_sel        = req_b[i*B_WIDTH +: B_WIDTH];
      end
    end
  end

  cnn_mul_share_dsp #(.AW(A_WIDTH), .BW(B_WIDTH)) u_dsp (
    .a (a1),
    .b (b1),
    .p (prod)
  );

  // Stall freezes everything, including rr_ptr, so a held entry is replayed exactly once.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
      s1_v   <= 1'b0;
      a1     <= '0;
      b1     <= '0;
      tag1   <= '0;
      s2_v   <= 1'b0;
      p2     <= '0;
      tag2   <= '0;
    end else if (!stall) begin
      s1_v <= grant;
      if (grant) begin
        a1     <= a_sel;
        b1     <= b_sel;
        tag1   <= TAG_W'(win_idx);
        rr_ptr <= (win_idx == 4'(NREQ - 1)) ? 4'd0 : win_idx + 4'd1;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        p2   <= prod;
        tag2 <= tag1;
      end
    end
  end

  assign res_valid = s2_v & ~stall;
  assign res_tag   = tag2;
  assign res_p     = p2;
  assign busy      = s1_v | s2_v;

endmodule
